// File: rtl/five_bit_serial_adder.sv
// Bit-serial adder: captures two WIDTH-bit operands, adds them LSB first through
// one full-adder cell, then presents sum, unsigned carry and signed overflow.
module five_bit_serial_adder #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             OVF,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;

    logic             sum_bit;
    logic             carry_out;

    // Single full-adder cell working on the current LSBs of the shift registers.
    assign sum_bit   = a_q[0] ^ b_q[0] ^ carry_q;
    assign carry_out = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        s_d         = s_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        in_ready    = 1'b0;

        unique case (state_q)
            IDLE: begin
                in_ready = ~rst;
                if (in_valid) begin
                    a_d     = A;
                    b_d     = B;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                sum_d   = {sum_bit, sum_q[WIDTH-1:1]};
                carry_d = carry_out;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    // carry_q here is the carry into the MSB, needed for signed overflow.
                    s_d         = {sum_bit, sum_q[WIDTH-1:1]};
                    cout_d      = carry_out;
                    ovf_d       = carry_q ^ carry_out;
                    out_valid_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            s_q         <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            s_q         <= s_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign S         = s_q;
    assign Cout      = cout_q;
    assign OVF       = ovf_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_five_bit_serial_adder.sv
// Self-checking bench for five_bit_serial_adder: directed corner cases, random
// operands with back-pressure, mid-run reset and an exhaustive back-to-back sweep.
module tb_five_bit_serial_adder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] A = '0;
    logic [4:0] B = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [4:0] S;
    logic       Cout;
    logic       OVF;
    logic       out_valid;
    logic       out_ready = 1'b1;

    int checks = 0;
    int failures = 0;
    time last_cap_t = 0;

    five_bit_serial_adder #(.WIDTH(5)) dut (
        .clk(clk), .rst(rst), .A(A), .B(B), .in_valid(in_valid), .in_ready(in_ready),
        .S(S), .Cout(Cout), .OVF(OVF), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic, unsigned and signed views of the operands.
    task automatic model(input int a, input int b, output int s, output int cout, output int ovf);
        int sa, sb, ssum;
        s    = (a + b) % 32;
        cout = ((a + b) >= 32) ? 1 : 0;
        sa   = (a >= 16) ? a - 32 : a;
        sb   = (b >= 16) ? b - 32 : b;
        ssum = sa + sb;
        ovf  = (ssum > 15 || ssum < -16) ? 1 : 0;
    endtask

    // Entered just after a falling edge with the DUT idle; returns just after the
    // falling edge that follows the DONE->IDLE edge.
    task automatic run_op(input int a, input int b, input int hold, input bit perturb, input string tag);
        int es, ec, eo;
        int lat;
        model(a, b, es, ec, eo);
        A         = 5'(a);
        B         = 5'(b);
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        check({tag, "_in_ready_idle"}, in_ready, 1);
        @(posedge clk);
        last_cap_t = $time;
        #1 in_valid = 1'b0;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) break;
            if (lat == 1) check({tag, "_in_ready_run"}, in_ready, 0);
            if (perturb) begin
                A        = 5'd0;
                B        = 5'd0;
                in_valid = ~in_valid;
            end
        end
        in_valid = 1'b0;
        check({tag, "_latency"}, lat, 5);
        check({tag, "_S"}, S, es);
        check({tag, "_Cout"}, Cout, ec);
        check({tag, "_OVF"}, OVF, eo);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, out_valid, 1);
            check({tag, "_hold_S"}, S, es);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check({tag, "_valid_clear"}, out_valid, 0);
        check({tag, "_in_ready_back"}, in_ready, 1);
        check({tag, "_S_retained"}, S, es);
    endtask

    initial begin
        #2;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_S", S, 0);
        check("rst_Cout", Cout, 0);
        check("rst_OVF", OVF, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 check("post_rst_in_ready", in_ready, 1);

        run_op(3, 4, 0, 1'b0, "add_3_4");
        run_op(31, 1, 0, 1'b0, "add_31_1");
        run_op(15, 1, 0, 1'b0, "add_15_1");
        run_op(16, 16, 0, 1'b0, "add_16_16");
        run_op(9, 10, 4, 1'b0, "hold_9_10");
        run_op(5, 6, 0, 1'b1, "perturb_5_6");

        // No second capture may come from the toggling in_valid above.
        repeat (3) begin
            @(negedge clk);
            check("no_second_capture", out_valid, 0);
        end
        check("no_second_capture_ready", in_ready, 1);

        // Reset in the third RUN cycle aborts the operation.
        A = 5'd7; B = 5'd9; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midrun_rst_out_valid", out_valid, 0);
        check("midrun_rst_S", S, 0);
        check("midrun_rst_in_ready", in_ready, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("after_abort_out_valid", out_valid, 0);
        check("after_abort_in_ready", in_ready, 1);
        run_op(2, 2, 0, 1'b0, "after_rst_2_2");

        for (int i = 0; i < 30; i++)
            run_op(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                   int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), "random");

        for (int i = 0; i < 1024; i++) begin
            time prev_t;
            prev_t = last_cap_t;
            run_op(i / 32, i % 32, 0, 1'b0, "exhaustive");
            if (i > 0) check("throughput_cycles", 32'((last_cap_t - prev_t) / 10), 7);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/five_bit_serial_adder.md
FIVE_BIT_SERIAL_ADDER -- requirements
Module: five_bit_serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 5, operand width; only 5 is required to be supported.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port A  input  5  addend, unsigned or two's complement.
REQ-005 SHALL have port B  input  5  addend, unsigned or two's complement.
REQ-006 SHALL have port in_valid  input  1  A/B valid.
REQ-007 SHALL have port in_ready  output  1  block can accept an operand pair.
REQ-008 SHALL have port S  output  5  sum A+B mod 32.
REQ-009 SHALL have port Cout  output  1  unsigned carry out of bit 4.
REQ-010 SHALL have port OVF  output  1  signed overflow: carry into bit 4 XOR Cout.
REQ-011 SHALL have port out_valid  output  1  S/Cout/OVF valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts result.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-014 SHALL drive in_ready = 1 only in IDLE with rst deasserted, and 0 in RUN and DONE.
REQ-015 SHALL capture A and B into internal shift registers, clear the carry flop, clear the bit counter and go IDLE->RUN on a rising edge with in_valid=1 and in_ready=1.
REQ-016 SHALL, in RUN, process one bit per cycle, LSB first, through a single full-adder cell: sum bit = a^b^c, carry = majority(a,b,c).
REQ-017 SHALL register carry between cycles, starting at 0; there is no carry-in port.
REQ-018 SHALL use a bit counter 0..4 in RUN and leave RUN after the edge that processes bit 4.
REQ-019 SHALL record the carry into bit 4, i.e. the carry flop value at the start of the bit-4 cycle, for the OVF computation.
REQ-020 SHALL, on the edge that processes bit 4, load S, Cout and OVF, set out_valid=1 and go RUN->DONE.
REQ-021 SHALL have latency of exactly 5 cycles: out_valid is first high in the 5th cycle after the capture edge.
REQ-022 SHALL hold S, Cout, OVF and out_valid stable in DONE while out_ready=0, for any number of cycles.
REQ-023 SHALL clear out_valid and go DONE->IDLE on a DONE edge with out_ready=1; S/Cout/OVF SHALL retain their values, and the next capture is possible one edge later.
REQ-024 SHALL ignore changes on A, B and in_valid during RUN and DONE; the captured operands are unaffected.
REQ-025 SHALL ignore out_ready outside DONE.
REQ-026 SHALL produce S equal to A+B truncated to 5 bits, and Cout equal to bit 5 of A+B, for all 1024 operand pairs.
REQ-027 SHALL have maximum throughput of one result per 7 cycles: capture, 5 RUN cycles, and 1 DONE cycle with out_ready=1.

Reset
REQ-028 SHALL, while rst=1 and independent of clk, force state IDLE, out_valid=0, S=0, Cout=0, OVF=0, carry=0, counter=0 and in_ready=0.
REQ-029 SHALL abort any in-flight operation on reset asserted in RUN or DONE; no result is produced for it.
REQ-030 SHALL, after rst deasserts, assert in_ready=1 and accept the first operand pair on the first rising edge.

Verification
REQ-031 SHALL pass: A=3, B=4, in_valid pulse -> out_valid high 5 cycles after capture, S=7, Cout=0, OVF=0.
REQ-032 SHALL pass: A=31, B=1 -> S=0, Cout=1, OVF=0.
REQ-033 SHALL pass: A=15, B=1 -> S=16, Cout=0, OVF=1; and A=16, B=16 -> S=0, Cout=1, OVF=1.
REQ-034 SHALL pass: A=9, B=10, out_ready held 0 for 4 cycles in DONE -> S=19 and out_valid=1 held throughout; out_ready=1 -> out_valid=0 and in_ready=1 on the next cycle.
REQ-035 SHALL pass: A=5, B=6, A/B changed to 0 and in_valid toggled during RUN -> S=11, no second capture.
REQ-036 SHALL pass: rst asserted asynchronously in the 3rd RUN cycle -> out_valid=0, S=0 immediately; after release, A=2, B=2 -> S=4 with 5-cycle latency.
REQ-037 SHALL pass: an exhaustive 1024-pair back-to-back run with out_ready=1 -> every result matches the reference sum, one result per 7 cycles.
